// File: rtl/hilo_mult_ctrl_pkg.sv
// Shared opcodes, FSM encoding and default timeout for the HI/LO multiply controller.
package hilo_mult_ctrl_pkg;
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MFHI  = 3'b011;
    localparam logic [2:0] OP_MFLO  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FIX} state_t;
endpackage

// File: rtl/hilo_mult_ctrl.sv
// HI/LO register file and sign-magnitude sequencer around an external unsigned multiplier.
module hilo_mult_ctrl
    import hilo_mult_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Op_valid,
    input  logic [2:0]         Op_code,
    input  logic [WIDTH-1:0]   Rs,
    input  logic [WIDTH-1:0]   Rt,
    output logic               Op_ready,
    output logic [WIDTH-1:0]   Rd_data,
    output logic               Rd_valid,
    output logic [WIDTH-1:0]   HI,
    output logic [WIDTH-1:0]   LO,
    output logic               Err,
    output logic               Mul_St,
    output logic [WIDTH-1:0]   Multiplicador,
    output logic [WIDTH-1:0]   Multiplicando,
    input  logic               Mul_Idle,
    input  logic               Mul_Done,
    input  logic [2*WIDTH-1:0] Produto
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             state;
    logic               sign;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;

    // Conditional two's-complement negation in 2*WIDTH-bit wrap arithmetic.
    function automatic logic [2*WIDTH-1:0] cond_neg(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [2*WIDTH-1:0] rs_abs, rt_abs, fixed;
    logic               unused_abs_hi;

    // Sign-extended before negation so -2^(WIDTH-1) yields 2^(WIDTH-1) in the low half.
    assign rs_abs        = cond_neg({{WIDTH{Rs[WIDTH-1]}}, Rs}, Rs[WIDTH-1]);
    assign rt_abs        = cond_neg({{WIDTH{Rt[WIDTH-1]}}, Rt}, Rt[WIDTH-1]);
    assign fixed         = cond_neg(prod, sign);
    assign unused_abs_hi = ^{rs_abs[2*WIDTH-1:WIDTH], rt_abs[2*WIDTH-1:WIDTH]};

    assign Op_ready = (state == S_IDLE) && Mul_Idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            HI            <= '0;
            LO            <= '0;
            Rd_data       <= '0;
            Rd_valid      <= 1'b0;
            Mul_St        <= 1'b0;
            Err           <= 1'b0;
            Multiplicador <= '0;
            Multiplicando <= '0;
            sign          <= 1'b0;
            prod          <= '0;
            cnt           <= '0;
        end else begin
            Rd_valid <= 1'b0;
            Mul_St   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Op_valid && Op_ready) begin
                        case (Op_code)
                            OP_MULT: begin
                                Multiplicador <= rs_abs[WIDTH-1:0];
                                Multiplicando <= rt_abs[WIDTH-1:0];
                                sign          <= Rs[WIDTH-1] ^ Rt[WIDTH-1];
                                Mul_St        <= 1'b1;
                                state         <= S_START;
                            end
                            OP_MULTU: begin
                                Multiplicador <= Rs;
                                Multiplicando <= Rt;
                                sign          <= 1'b0;
                                Mul_St        <= 1'b1;
                                state         <= S_START;
                            end
                            OP_MFHI: begin
                                Rd_data  <= HI;
                                Rd_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                Rd_data  <= LO;
                                Rd_valid <= 1'b1;
                            end
                            OP_MTHI: HI <= Rs;
                            OP_MTLO: LO <= Rs;
                            default: ;
                        endcase
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (Mul_Done) begin
                        prod  <= Produto;
                        state <= S_FIX;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        Err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    {HI, LO} <= fixed;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl with a 32-cycle behavioural multiplier alongside.
module tb_hilo_mult_ctrl;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           Op_valid = 1'b0;
    logic [2:0]     Op_code = 3'b000;
    logic [W-1:0]   Rs = '0, Rt = '0;
    logic           Op_ready, Rd_valid, Err, Mul_St, Mul_Idle, Mul_Done;
    logic [W-1:0]   Rd_data, HI, LO, Multiplicador, Multiplicando;
    logic [2*W-1:0] Produto;

    int total = 0;
    int bad   = 0;

    hilo_mult_ctrl #(.WIDTH(W), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .Op_valid(Op_valid), .Op_code(Op_code), .Rs(Rs), .Rt(Rt),
        .Op_ready(Op_ready), .Rd_data(Rd_data), .Rd_valid(Rd_valid), .HI(HI), .LO(LO),
        .Err(Err), .Mul_St(Mul_St), .Multiplicador(Multiplicador), .Multiplicando(Multiplicando),
        .Mul_Idle(Mul_Idle), .Mul_Done(Mul_Done), .Produto(Produto)
    );

    always #5 clk = ~clk;

    // Multiplier model: Done rises 32 edges after the edge that samples St; not reset by rst.
    int             mcnt = 0;
    logic           mdone = 1'b0;
    logic           tie_done = 1'b0;
    logic [2*W-1:0] mprod = '0;
    always @(posedge clk) begin
        if (Mul_St) begin
            mcnt  <= 32;
            mprod <= {{W{1'b0}}, Multiplicador} * {{W{1'b0}}, Multiplicando};
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
        mdone <= (mcnt == 1);
    end
    assign Mul_Done = mdone & ~tie_done;
    assign Mul_Idle = (mcnt == 0) && !mdone;
    assign Produto  = mprod;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present an op and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        Op_valid = 1'b1; Op_code = code; Rs = a; Rt = b;
        while (!Op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 Op_valid = 1'b0;
    endtask

    // Count negedge samples with Op_ready low until it returns high.
    task automatic busy_cycles(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (Op_ready || n >= 500) break;
            n++;
        end
    endtask

    int n;

    initial begin
        #1;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_err", Err, 0);
        chk("rst_st", Mul_St, 0);
        chk("rst_rdv", Rd_valid, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", Op_ready, 1);

        // MTHI/MTLO then back-to-back MFHI/MFLO
        op(OP_MTHI_C(), 16'h1234, 16'h0);
        op(3'b110, 16'hABCD, 16'h0);
        chk("mthi", HI, 16'h1234);
        chk("mtlo", LO, 16'hABCD);
        @(negedge clk);
        Op_valid = 1'b1; Op_code = 3'b011;
        @(posedge clk); #1;
        chk("mfhi_v", Rd_valid, 1);
        chk("mfhi_d", Rd_data, 16'h1234);
        Op_code = 3'b100;
        @(posedge clk); #1;
        chk("mflo_v", Rd_valid, 1);
        chk("mflo_d", Rd_data, 16'hABCD);
        Op_valid = 1'b0;
        @(posedge clk); #1;
        chk("rdv_drop", Rd_valid, 0);

        // MULTU 5000 x 6000 with busy-window length
        op(3'b010, 16'd5000, 16'd6000);
        busy_cycles(n);
        chk("multu_busy", n, 35);
        chk("multu_hi", HI, 16'h01C9);
        chk("multu_lo", LO, 16'hC380);

        // MULT -3 x 15: magnitudes, start pulse shape, negated result
        op(3'b001, 16'hFFFD, 16'd15);
        chk("mult_st1", Mul_St, 1);
        chk("mult_mdor", Multiplicador, 3);
        chk("mult_mdo", Multiplicando, 15);
        @(posedge clk); #1;
        chk("mult_st0", Mul_St, 0);
        repeat (5) @(posedge clk); #1;
        chk("wait_hold", Multiplicador, 3);
        busy_cycles(n);
        chk("mult_hi", HI, 16'hFFFF);
        chk("mult_lo", LO, 16'hFFD3);

        // MULTU FFFF x FFFF with an MFLO held through the busy period
        op(3'b010, 16'hFFFF, 16'hFFFF);
        Op_valid = 1'b1; Op_code = 3'b100;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!Rd_valid && n < 200);
        Op_valid = 1'b0;
        chk("held_mflo", Rd_data, 16'h0001);
        chk("ffff_hi", HI, 16'hFFFE);

        // MULT most-negative squared
        op(3'b001, 16'h8000, 16'h8000);
        chk("min_mdor", Multiplicador, 16'h8000);
        busy_cycles(n);
        chk("min_hi", HI, 16'h4000);
        chk("min_lo", LO, 16'h0000);

        // NOP and reserved leave state alone
        op(3'b000, 16'h7777, 16'h7777);
        op(3'b111, 16'h7777, 16'h7777);
        @(negedge clk);
        chk("nop_hi", HI, 16'h4000);
        chk("nop_ready", Op_ready, 1);
        chk("nop_rdv", Rd_valid, 0);

        // Timeout: Done suppressed
        tie_done = 1'b1;
        op(3'b001, 16'd7, 16'd9);
        n = 0;
        forever begin
            @(negedge clk);
            if (Err || n >= 500) break;
            n++;
        end
        chk("to_cycles", n, 65);
        chk("to_err", Err, 1);
        chk("to_hi", HI, 16'h4000);
        chk("to_lo", LO, 16'h0000);
        repeat (2) @(negedge clk);
        chk("to_ready", Op_ready, 1);
        tie_done = 1'b0;
        op(3'b101, 16'h0055, 16'h0);
        chk("err_sticky", Err, 1);
        chk("mthi2", HI, 16'h0055);

        // Reset 10 cycles into WAIT, then a late Done
        op(3'b010, 16'd300, 16'd7);
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_hi", HI, 0);
        chk("ar_err", Err, 0);
        chk("ar_mdor", Multiplicador, 0);
        chk("ar_mdo", Multiplicando, 0);
        chk("ar_st", Mul_St, 0);
        chk("ar_rdd", Rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!mdone && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("late_done_seen", mdone, 1);
        repeat (3) @(negedge clk);
        chk("late_hi", HI, 0);
        chk("late_lo", LO, 0);
        chk("late_ready", Op_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [2:0] OP_MTHI_C();
        return 3'b101;
    endfunction
endmodule

// File: doc/hilo_mult_ctrl.md
HILO_MULT_CTRL -- requirements
Module: hilo_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width; the product is 2*WIDTH bits.
REQ-002 Parameter TIMEOUT, default 64, maximum number of cycles spent in WAIT.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Op_valid  input  1  an instruction is presented.
REQ-006 Op_code  input  3  000 NOP, 001 MULT, 010 MULTU, 011 MFHI, 100 MFLO, 101 MTHI, 110 MTLO, 111 reserved.
REQ-007 Rs, Rt  input  WIDTH each  source operands.
REQ-008 Op_ready  output  1  the block accepts an instruction in this cycle.
REQ-009 Rd_data  output  WIDTH  MFHI/MFLO result; Rd_valid  output  1  one-cycle qualifier for Rd_data.
REQ-010 HI, LO  output  WIDTH each  architectural HI/LO registers.
REQ-011 Err  output  1  sticky multiplier-timeout flag.
REQ-012 Mul_St  output  1  start pulse to the multiplier.
REQ-013 Multiplicador, Multiplicando  output  WIDTH each  unsigned operands to the multiplier.
REQ-014 Mul_Idle, Mul_Done  input  1 each  multiplier status.
REQ-015 Produto  input  2*WIDTH  unsigned multiplier result.

Function
REQ-016 FSM states: IDLE, START, WAIT, FIX; Op_ready SHALL be 1 only in IDLE, and only when Mul_Idle=1.
REQ-017 An instruction is accepted on the edge where Op_valid=1 and Op_ready=1.
REQ-018 NOP, reserved, or Op_valid=0: no state change.
REQ-019 MTHI/MTLO: HI or LO is loaded with Rs on the accepting edge; the FSM stays in IDLE.
REQ-020 MFHI/MFLO: Rd_data is loaded with HI or LO on the accepting edge, and Rd_valid is 1 for exactly the following cycle.
REQ-021 MULTU: latch |operands| = Rs, Rt and a result-sign bit of 0; go to START.
REQ-022 MULT: latch the two's-complement magnitudes of Rs and Rt, and result sign = Rs[WIDTH-1] xor Rt[WIDTH-1]; the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), unsigned.
REQ-023 START: Mul_St = 1 for exactly one cycle, with Multiplicador = latched Rs magnitude and Multiplicando = latched Rt magnitude; next state is WAIT.
REQ-024 WAIT: hold the operands stable and Mul_St = 0; on Mul_Done = 1, capture Produto and go to FIX.
REQ-025 FIX: {HI,LO} = sign ? two's-complement negation of the captured product : the captured product (2*WIDTH-bit wrap arithmetic); next state is IDLE.
REQ-026 Latency: HI/LO are updated 3 cycles after the multiplier's own start-to-Done latency, counted from the accepting edge.
REQ-027 WAIT cycle counter: when it reaches TIMEOUT without Mul_Done, set Err, leave HI/LO unchanged, and return to IDLE.
REQ-028 Mul_Done while not in WAIT is ignored.
REQ-029 Op_valid held during a busy period is not lost; it is accepted on the first cycle Op_ready returns to 1.

Reset
REQ-030 rst = 1 immediately forces: state = IDLE; HI, LO, Rd_data = 0; Rd_valid, Mul_St, Err = 0; Multiplicador, Multiplicando = 0; counter = 0.
REQ-031 Reset during START, WAIT, or FIX abandons the operation; a late Mul_Done after reset release is ignored per REQ-028.
REQ-032 Err clears only on rst.

Structure
REQ-033 Shared package contents: Op_code constants, FSM state encoding, default TIMEOUT.
REQ-034 No sub-module: the multiplier is instantiated beside this block at the next level up, not inside it.
REQ-035 The magnitude/negation logic is a single combinational function, reused by REQ-022 and REQ-025.

Verification
REQ-036 The bench uses a behavioural multiplier model with Done 32 cycles after St.
REQ-037 MULTU Rs = 5000, Rt = 6000 -> HI = 0x01C9, LO = 0xC380; Op_ready low for 35 cycles.
REQ-038 MULT Rs = 0xFFFD (-3), Rt = 15 -> Multiplicador = 3, HI = 0xFFFF, LO = 0xFFD3.
REQ-039 MULTU 0xFFFF x 0xFFFF -> HI = 0xFFFE, LO = 0x0001; MULT 0x8000 x 0x8000 -> HI = 0x4000, LO = 0x0000.
REQ-040 MTHI 0x1234, MTLO 0xABCD, then MFHI and MFLO back-to-back -> Rd_data = 0x1234 then 0xABCD, with Rd_valid asserted on consecutive cycles.
REQ-041 MULT with Mul_Done tied to 0 -> Err = 1 after 64 WAIT cycles, HI/LO unchanged, Op_ready = 1 afterwards.
REQ-042 rst pulsed 10 cycles into WAIT -> all outputs 0 at once, and a Done arriving later leaves HI/LO = 0.
